demux_clk: RTL and testbench
============================

# demux_clk

Clocked two-way demultiplexer (split) for the GCD datapath's 2-phase bundled-data channels. It consumes one data token on input channel A and one selector token on the select channel, then forwards the data to output B (selector=0) or output C (selector=1). It completes the input handshakes only after the chosen output has acknowledged. It is the steering counterpart of the merging mux and sits where a GCD operand is routed back to either the subtract path or the result path.

## Interface
- DATA_WIDTH, 32, width of data on all channels
- SYNC_STAGES, 2, flip-flop synchronizer depth on each incoming req/ack (0 = inputs used directly)

- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_inA_req  in  1  input data channel request (2-phase toggle)
- i_inA_data  in  DATA_WIDTH  input data, stable while i_inA_req != o_inA_ack
- o_inA_ack  out  1  input data channel acknowledge (toggle)
- i_inSel_req  in  1  select channel request (toggle)
- i_selector  in  1  route select, stable while i_inSel_req != o_inSel_ack
- o_inSel_ack  out  1  select channel acknowledge (toggle)
- o_outB_req  out  1  output B request (toggle)
- o_outB_data  out  DATA_WIDTH  output B data
- i_outB_ack  in  1  output B acknowledge (toggle)
- o_outC_req  out  1  output C request (toggle)
- o_outC_data  out  DATA_WIDTH  output C data
- i_outC_ack  in  1  output C acknowledge (toggle)

## Operation
- Protocol: 2-phase. Input channel pending ⇔ synced req != own ack. Output transfer complete ⇔ synced ack == own req.
- Synchronizers: i_inA_req, i_inSel_req, i_outB_ack, i_outC_ack each pass through SYNC_STAGES flops. i_inA_data and i_selector are sampled unsynchronized; bundled-data timing guarantees stability.
- FSM states: IDLE, BUSY.
- IDLE:
  - Wait until inA and inSel are both pending.
  - On that edge: latch sel_q = i_selector.
  - selector=0: o_outB_data <= i_inA_data, o_outB_req toggles.
  - selector=1: o_outC_data <= i_inA_data, o_outC_req toggles.
  - Go to BUSY.
- BUSY:
  - Wait for synced ack of the selected output to equal its req.
  - On that edge: toggle o_inA_ack and o_inSel_ack together, go to IDLE.
- One token in flight maximum.
- The unselected output's req and data never change during a transfer.
- Output data holds the last value sent to that channel until the next transfer to the same channel.
- Only one input pending: stay in IDLE indefinitely; no output activity.
- Ack toggle on the unselected output while BUSY: protocol violation; ignored, with no state change.
- Back-to-back: after input acks toggle, the next transfer starts as soon as both synced reqs differ again. Input acks toggle on edge e; the new request is detectable no earlier than edge e+1+SYNC_STAGES.

## Timing
- Reset (i_rstn=0, asynchronous):
  - All acks, reqs and data outputs = 0.
  - Sync flops = 0, state = IDLE, sel_q = 0.
- Reset mid-transfer: aborts the token, all phases return to 0. Neighbouring blocks must be reset in the same window.
- Forward latency: both input reqs toggled before edge k → output req toggles at edge k+SYNC_STAGES.
- Backward latency: output ack toggled before edge m → input acks toggle at edge m+SYNC_STAGES.
- Minimum cycle per token, with instant external response: 2·(SYNC_STAGES+1) clocks.

## Test plan
- SYNC_STAGES=0, reset then data 0x0000_00A5 with selector=0:
  - Toggle both input reqs before edge 1 → o_outB_req=1 and o_outB_data=0xA5 at edge 1; C outputs stay 0.
  - Ack B before edge 3 → o_inA_ack=o_inSel_ack=1 at edge 3.
- Selector=1, data 0xDEAD_BEEF → only o_outC_req toggles, o_outC_data=0xDEADBEEF; B req/data unchanged from the prior value (0xA5).
- Skew: toggle inA_req 5 cycles before inSel_req → no output toggle until the cycle after inSel_req is seen; stray toggle of i_outC_ack during a B transfer → no input ack.
- SYNC_STAGES=2, back-to-back stream of 8 tokens with alternating selector and an immediate-ack responder:
  - Every token is delivered to the correct channel in order.
  - Per-token period is exactly 6 clocks.
- Assert i_rstn low while BUSY (output req toggled, no ack yet) → all outputs 0 immediately; after release, a fresh token with data 0x1234 and selector=1 completes normally.

Source files
------------

// File: rtl/demux_clk_if.sv
// Bundled-data 2-phase channel bundle for demux_clk: data/select inputs and the B/C outputs.
// Signal names keep the i_/o_ prefixes as seen from the demux itself.
interface demux_clk_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_inA_req;
  logic [DATA_WIDTH-1:0] i_inA_data;
  logic                  o_inA_ack;
  logic                  i_inSel_req;
  logic                  i_selector;
  logic                  o_inSel_ack;
  logic                  o_outB_req;
  logic [DATA_WIDTH-1:0] o_outB_data;
  logic                  i_outB_ack;
  logic                  o_outC_req;
  logic [DATA_WIDTH-1:0] o_outC_data;
  logic                  i_outC_ack;

  modport slave (
    input  i_inA_req, i_inA_data, i_inSel_req, i_selector, i_outB_ack, i_outC_ack,
    output o_inA_ack, o_inSel_ack, o_outB_req, o_outB_data, o_outC_req, o_outC_data
  );

  modport master (
    output i_inA_req, i_inA_data, i_inSel_req, i_selector, i_outB_ack, i_outC_ack,
    input  o_inA_ack, o_inSel_ack, o_outB_req, o_outB_data, o_outC_req, o_outC_data
  );
endinterface

// File: rtl/demux_clk.sv
// Clocked 2-phase demultiplexer: steers one data token from A to B (sel=0) or C (sel=1),
// completing the input handshakes only once the chosen output has acknowledged.
module demux_clk #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  demux_clk_if.slave  ch
);
  typedef enum logic {IDLE, BUSY} state_e;

  // bit order: {outC_ack, outB_ack, inSel_req, inA_req}
  logic [3:0] raw, synced;
  assign raw = {ch.i_outC_ack, ch.i_outB_ack, ch.i_inSel_req, ch.i_inA_req};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign synced = raw;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    always_comb begin
      sync_d    = sync_q;
      sync_d[0] = raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) sync_q <= '0;
      else         sync_q <= sync_d;
    end
    assign synced = sync_q[SYNC_STAGES-1];
  end

  state_e                state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  inA_ack_q, inA_ack_d;
  logic                  inSel_ack_q, inSel_ack_d;
  logic                  outB_req_q, outB_req_d;
  logic                  outC_req_q, outC_req_d;
  logic [DATA_WIDTH-1:0] outB_data_q, outB_data_d;
  logic [DATA_WIDTH-1:0] outC_data_q, outC_data_d;

  logic a_pend, s_pend, out_done;
  assign a_pend   = synced[0] != inA_ack_q;
  assign s_pend   = synced[1] != inSel_ack_q;
  // Only the selected output's ack is looked at; the other one is ignored entirely.
  assign out_done = sel_q ? (synced[3] == outC_req_q) : (synced[2] == outB_req_q);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    inA_ack_d   = inA_ack_q;
    inSel_ack_d = inSel_ack_q;
    outB_req_d  = outB_req_q;
    outC_req_d  = outC_req_q;
    outB_data_d = outB_data_q;
    outC_data_d = outC_data_q;
    case (state_q)
      IDLE: if (a_pend && s_pend) begin
        sel_d = ch.i_selector;
        if (ch.i_selector) begin
          outC_data_d = ch.i_inA_data;
          outC_req_d  = ~outC_req_q;
        end else begin
          outB_data_d = ch.i_inA_data;
          outB_req_d  = ~outB_req_q;
        end
        state_d = BUSY;
      end
      BUSY: if (out_done) begin
        inA_ack_d   = ~inA_ack_q;
        inSel_ack_d = ~inSel_ack_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      inA_ack_q   <= 1'b0;
      inSel_ack_q <= 1'b0;
      outB_req_q  <= 1'b0;
      outC_req_q  <= 1'b0;
      outB_data_q <= '0;
      outC_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      inA_ack_q   <= inA_ack_d;
      inSel_ack_q <= inSel_ack_d;
      outB_req_q  <= outB_req_d;
      outC_req_q  <= outC_req_d;
      outB_data_q <= outB_data_d;
      outC_data_q <= outC_data_d;
    end
  end

  assign ch.o_inA_ack   = inA_ack_q;
  assign ch.o_inSel_ack = inSel_ack_q;
  assign ch.o_outB_req  = outB_req_q;
  assign ch.o_outC_req  = outC_req_q;
  assign ch.o_outB_data = outB_data_q;
  assign ch.o_outC_data = outC_data_q;
endmodule

// File: tb/tb_demux_clk.sv
// Directed bench: an unsynchronized instance for exact-edge checks and a
// SYNC_STAGES=2 instance for the back-to-back token stream.
module tb_demux_clk;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  demux_clk_if #(.DATA_WIDTH(32)) if0 ();
  demux_clk_if #(.DATA_WIDTH(32)) if2 ();

  demux_clk #(.DATA_WIDTH(32), .SYNC_STAGES(0)) u0 (.i_clk(clk), .i_rstn(rstn), .ch(if0.slave));
  demux_clk #(.DATA_WIDTH(32), .SYNC_STAGES(2)) u2 (.i_clk(clk), .i_rstn(rstn), .ch(if2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    if0.i_inA_req = 0; if0.i_inA_data = '0; if0.i_inSel_req = 0; if0.i_selector = 0;
    if0.i_outB_ack = 0; if0.i_outC_ack = 0;
    if2.i_inA_req = 0; if2.i_inA_data = '0; if2.i_inSel_req = 0; if2.i_selector = 0;
    if2.i_outB_ack = 0; if2.i_outC_ack = 0;
  endtask

  initial begin
    int   cyc, delivered, issued, last;
    logic pb, pc, exp_sel;
    clear_inputs();
    tick(); tick();
    chk("rst inA_ack",   32'(if0.o_inA_ack),   0);
    chk("rst inSel_ack", 32'(if0.o_inSel_ack), 0);
    chk("rst outB_req",  32'(if0.o_outB_req),  0);
    chk("rst outC_req",  32'(if0.o_outC_req),  0);
    chk("rst outB_data", if0.o_outB_data,      0);
    chk("rst outC_data", if0.o_outC_data,      0);
    rstn = 1'b1;

    // token 1: 0xA5 to B
    if0.i_inA_data = 32'h0000_00A5; if0.i_selector = 0;
    if0.i_inA_req = 1; if0.i_inSel_req = 1;
    tick();
    chk("t1 outB_req",  32'(if0.o_outB_req), 1);
    chk("t1 outB_data", if0.o_outB_data,     32'hA5);
    chk("t1 outC_req",  32'(if0.o_outC_req), 0);
    chk("t1 outC_data", if0.o_outC_data,     0);
    tick();
    chk("t1 ack held",  32'(if0.o_inA_ack),  0);
    if0.i_outB_ack = 1;
    tick();
    chk("t1 inA_ack",   32'(if0.o_inA_ack),   1);
    chk("t1 inSel_ack", 32'(if0.o_inSel_ack), 1);

    // token 2: 0xDEADBEEF to C
    if0.i_inA_data = 32'hDEAD_BEEF; if0.i_selector = 1;
    if0.i_inA_req = 0; if0.i_inSel_req = 0;
    tick();
    chk("t2 outC_req",  32'(if0.o_outC_req), 1);
    chk("t2 outC_data", if0.o_outC_data,     32'hDEAD_BEEF);
    chk("t2 outB_req",  32'(if0.o_outB_req), 1);
    chk("t2 outB_data", if0.o_outB_data,     32'hA5);
    if0.i_outC_ack = 1;
    tick();
    chk("t2 inA_ack",   32'(if0.o_inA_ack),   0);
    chk("t2 inSel_ack", 32'(if0.o_inSel_ack), 0);

    // skew: data req 5 cycles ahead of select req
    if0.i_inA_data = 32'h0000_0055; if0.i_selector = 0;
    if0.i_inA_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("skew outB_req", 32'(if0.o_outB_req), 1);
      chk("skew outC_req", 32'(if0.o_outC_req), 1);
    end
    if0.i_inSel_req = 1;
    tick();
    chk("skew fire req",  32'(if0.o_outB_req), 0);
    chk("skew fire data", if0.o_outB_data,     32'h55);
    // stray ack on the unselected output
    if0.i_outC_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray inA_ack", 32'(if0.o_inA_ack), 0);
      chk("stray outC_req", 32'(if0.o_outC_req), 1);
    end
    if0.i_outB_ack = 0;
    tick();
    chk("skew inA_ack",   32'(if0.o_inA_ack),   1);
    chk("skew inSel_ack", 32'(if0.o_inSel_ack), 1);

    // SYNC_STAGES=2 stream, immediate-ack responder
    cyc = 0; delivered = 0; issued = 0; last = 0;
    pb = if2.o_outB_req; pc = if2.o_outC_req;
    while (delivered < 8 && cyc < 300) begin
      if (issued < 8 && if2.o_inA_ack == if2.i_inA_req && if2.o_inSel_ack == if2.i_inSel_req) begin
        if2.i_inA_data = 32'hC0DE_0000 + 32'(issued);
        if2.i_selector = issued[0];
        if2.i_inA_req  = ~if2.i_inA_req;
        if2.i_inSel_req = ~if2.i_inSel_req;
        issued++;
      end
      tick();
      cyc++;
      exp_sel = delivered[0];
      if (if2.o_outB_req != pb || if2.o_outC_req != pc) begin
        chk("s2 chan", 32'(if2.o_outC_req != pc), 32'(exp_sel));
        chk("s2 both", 32'(if2.o_outB_req != pb && if2.o_outC_req != pc), 0);
        chk("s2 data", (if2.o_outC_req != pc) ? if2.o_outC_data : if2.o_outB_data,
            32'hC0DE_0000 + 32'(delivered));
        if (delivered > 0) chk("s2 period", 32'(cyc - last), 6);
        last = cyc;
        delivered++;
        pb = if2.o_outB_req; pc = if2.o_outC_req;
      end
      if2.i_outB_ack = if2.o_outB_req;
      if2.i_outC_ack = if2.o_outC_req;
    end
    chk("s2 delivered", 32'(delivered), 8);

    // reset while BUSY on the unsynchronized instance
    if0.i_inA_data = 32'h0000_0077; if0.i_selector = 0;
    if0.i_inA_req = 0; if0.i_inSel_req = 0;
    tick();
    chk("rb outB_req", 32'(if0.o_outB_req), 1);
    rstn = 1'b0;
    clear_inputs();
    #1;
    chk("rb async outB_req",  32'(if0.o_outB_req),  0);
    chk("rb async outB_data", if0.o_outB_data,      0);
    chk("rb async inA_ack",   32'(if0.o_inA_ack),   0);
    chk("rb async outC_req",  32'(if0.o_outC_req),  0);
    tick();
    rstn = 1'b1;
    if0.i_inA_data = 32'h0000_1234; if0.i_selector = 1;
    if0.i_inA_req = 1; if0.i_inSel_req = 1;
    tick();
    chk("rb outC_req",  32'(if0.o_outC_req), 1);
    chk("rb outC_data", if0.o_outC_data,     32'h1234);
    chk("rb outB_req",  32'(if0.o_outB_req), 0);
    if0.i_outC_ack = 1;
    tick();
    chk("rb inA_ack",   32'(if0.o_inA_ack),   1);
    chk("rb inSel_ack", 32'(if0.o_inSel_ack), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
